// File: rtl/stack_pointer_ctrl_pkg.sv
// Shared constants and state encoding for the stack pointer controller.
package stack_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  // IDLE waits for a request, WR writes the captured value, RD issues the
  // read address, CAP captures the RAM read data one cycle later.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_CAP  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_pointer_ctrl_if.sv
// Request/response and RAM-side signals of the stack pointer controller.
// The controller uses the slave view; the environment (requester plus RAM)
// uses the master view.
interface stack_pointer_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;

  modport master (
    output push, pop, push_data, mem_rdata,
    input  busy, done, pop_data, mem_addr, mem_we, mem_wdata,
           count, full, empty, ovf, unf
  );

  modport slave (
    input  push, pop, push_data, mem_rdata,
    output busy, done, pop_data, mem_addr, mem_we, mem_wdata,
           count, full, empty, ovf, unf
  );

endinterface

// File: rtl/stack_pointer_ctrl_counter.sv
// Up/down entry counter. Clear wins over everything; inc and dec together
// cancel out (the controller never asserts both).
module updown_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  // count register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/stack_pointer_ctrl.sv
// LIFO stack controller in front of an external 1-cycle-latency RAM.
//
//   state | meaning
//   IDLE  | accept push/pop; flag overflow/underflow on illegal requests
//   WR    | write captured value at address count, count + 1
//   RD    | present address count-1 to the RAM
//   CAP   | latch RAM read data into pop_data, count - 1
module stack_pointer_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                clk,
  input logic                clr,
  stack_pointer_ctrl_if.slave bus
);

  localparam int unsigned    DEPTH_L  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH_L);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_m1;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] wreg;
  logic [DATA_W-1:0] pop_data_q;
  logic              done_q;
  logic              ovf_q;
  logic              unf_q;

  logic              wreg_load;
  logic              pop_load;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              done_set;
  logic              ovf_set;
  logic              unf_set;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;

  updown_counter #(.W(ADDR_W + 1)) u_count (
    .clk (clk),
    .clr (clr),
    .inc (cnt_inc),
    .dec (cnt_dec),
    .cnt (count)
  );

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign count_m1 = count - (ADDR_W + 1)'(1);

  // state register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, RAM strobes and datapath enables
  always_comb begin
    state_d    = state_q;
    wreg_load  = 1'b0;
    pop_load   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    done_set   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = count[ADDR_W-1:0];
    case (state_q)
      ST_IDLE: begin
        // simultaneous push and pop is deliberately a no-op
        if (bus.push && !bus.pop) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            wreg_load = 1'b1;
            state_d   = ST_WR;
          end
        end else if (bus.pop && !bus.push) begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        mem_we_c = 1'b1;
        cnt_inc  = 1'b1;
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_RD: begin
        mem_addr_c = count_m1[ADDR_W-1:0];
        state_d    = ST_CAP;
      end
      ST_CAP: begin
        pop_load = 1'b1;
        cnt_dec  = 1'b1;
        done_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // write register, pop data, completion pulse and sticky error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      wreg       <= '0;
      pop_data_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (wreg_load) wreg <= bus.push_data;
      if (pop_load) pop_data_q <= bus.mem_rdata;
      done_q <= done_set;
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = wreg;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Bench for stack_pointer_ctrl: directed stimulus, scoreboard of expected
// completions checked by an independent done monitor, plus inline checks.
module tb_stack_pointer_ctrl;

  logic clk = 1'b0;
  logic clr;
  int   tests_run = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stack_pointer_ctrl_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  stack_pointer_ctrl #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // external synchronous RAM, one cycle read latency
  logic [7:0] ram [32];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    int         done_cyc;
    logic [7:0] pop_data;
    logic [5:0] count;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_pop = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_done_cycle"}, cyc, e.done_cyc);
        check({e.name, "_count"}, {26'd0, bus.count}, {26'd0, e.count});
        check({e.name, "_pop_data"}, {24'd0, bus.pop_data}, {24'd0, e.pop_data});
      end
    end
  end

  task automatic expect_done(input int dcyc, input logic [5:0] cnt, input string name);
    exp_t e;
    e.done_cyc = dcyc;
    e.pop_data = exp_pop;
    e.count    = cnt;
    e.name     = name;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_pop = 8'h00;
  endtask

  task automatic do_push(input logic [7:0] d, input logic [5:0] cnt_after, input logic [4:0] addr);
    @(posedge clk); #1;
    bus.push      = 1'b1;
    bus.push_data = d;
    expect_done(cyc + 2, cnt_after, "push");
    @(posedge clk); #1;
    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    @(negedge clk);
    check("push_we", {31'd0, bus.mem_we}, 32'd1);
    check("push_addr", {27'd0, bus.mem_addr}, {27'd0, addr});
    check("push_wdata", {24'd0, bus.mem_wdata}, {24'd0, d});
    drain(8);
  endtask

  task automatic do_pop(input logic [7:0] d, input logic [5:0] cnt_after);
    @(posedge clk); #1;
    bus.pop = 1'b1;
    exp_pop = d;
    expect_done(cyc + 3, cnt_after, "pop");
    @(posedge clk); #1;
    bus.pop = 1'b0;
    @(negedge clk);
    check("pop_rd_we", {31'd0, bus.mem_we}, 32'd0);
    check("pop_rd_addr", {27'd0, bus.mem_addr}, {27'd0, cnt_after[4:0]});
    drain(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr           = 1'b1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_count", {26'd0, bus.count}, 32'd0);
    check("rst_pop_data", {24'd0, bus.pop_data}, 32'd0);
    check("rst_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);
    check("rst_addr", {27'd0, bus.mem_addr}, 32'd0);

    // single push
    do_push(8'h05, 6'd1, 5'd0);
    check("push1_count", {26'd0, bus.count}, 32'd1);

    // LIFO order
    do_clr();
    do_push(8'h01, 6'd1, 5'd0);
    do_push(8'h02, 6'd2, 5'd1);
    do_push(8'h03, 6'd3, 5'd2);
    do_pop(8'h03, 6'd2);
    do_pop(8'h02, 6'd1);
    do_pop(8'h01, 6'd0);
    check("lifo_empty", {31'd0, bus.empty}, 32'd1);
    check("lifo_count", {26'd0, bus.count}, 32'd0);

    // back-to-back: second push issued in the cycle done is high
    do_clr();
    @(posedge clk); #1;
    bus.push = 1'b1; bus.push_data = 8'hA1;
    expect_done(cyc + 2, 6'd1, "b2b_push_a");
    @(posedge clk); #1;
    bus.push = 1'b0;
    @(posedge clk); #1;
    check("b2b_done_high", {31'd0, bus.done}, 32'd1);
    bus.push = 1'b1; bus.push_data = 8'hB2;
    expect_done(cyc + 2, 6'd2, "b2b_push_b");
    @(posedge clk); #1;
    bus.push = 1'b0;
    drain(8);
    do_pop(8'hB2, 6'd1);

    // fill to 32, then overflow
    do_clr();
    for (int i = 0; i < 32; i++) begin
      do_push(8'(8'h10 + i), 6'(i + 1), 5'(i));
    end
    check("fill_full", {31'd0, bus.full}, 32'd1);
    check("fill_count", {26'd0, bus.count}, 32'd32);
    @(posedge clk); #1;
    bus.push = 1'b1; bus.push_data = 8'hEE;
    @(negedge clk);
    check("ovf_req_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    bus.push = 1'b0;
    @(negedge clk);
    check("ovf_we", {31'd0, bus.mem_we}, 32'd0);
    check("ovf_busy", {31'd0, bus.busy}, 32'd0);
    check("ovf_flag", {31'd0, bus.ovf}, 32'd1);
    check("ovf_count", {26'd0, bus.count}, 32'd32);
    repeat (3) @(negedge clk);
    do_pop(8'h2F, 6'd31);

    // underflow on pop right after clear
    do_clr();
    @(posedge clk); #1;
    bus.pop = 1'b1;
    @(posedge clk); #1;
    bus.pop = 1'b0;
    @(negedge clk);
    check("unf_flag", {31'd0, bus.unf}, 32'd1);
    check("unf_busy", {31'd0, bus.busy}, 32'd0);
    check("unf_ovf_clear", {31'd0, bus.ovf}, 32'd0);
    check("unf_count", {26'd0, bus.count}, 32'd0);
    repeat (4) @(negedge clk);

    // push and pop together: no-op
    do_clr();
    do_push(8'h0A, 6'd1, 5'd0);
    @(posedge clk); #1;
    bus.push = 1'b1; bus.pop = 1'b1; bus.push_data = 8'h99;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0;
    @(negedge clk);
    check("both_busy", {31'd0, bus.busy}, 32'd0);
    check("both_we", {31'd0, bus.mem_we}, 32'd0);
    check("both_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);
    check("both_count", {26'd0, bus.count}, 32'd1);
    repeat (3) @(negedge clk);

    // push during RD is ignored
    @(posedge clk); #1;
    bus.pop = 1'b1;
    exp_pop = 8'h0A;
    expect_done(cyc + 3, 6'd0, "pop_rd_push");
    @(posedge clk); #1;
    bus.pop = 1'b0; bus.push = 1'b1; bus.push_data = 8'h77;
    @(posedge clk); #1;
    bus.push = 1'b0;
    drain(8);
    repeat (3) @(negedge clk);
    check("rdpush_count", {26'd0, bus.count}, 32'd0);
    check("rdpush_busy", {31'd0, bus.busy}, 32'd0);
    check("rdpush_empty", {31'd0, bus.empty}, 32'd1);

    // clear during CAP aborts the pop
    do_clr();
    do_push(8'h33, 6'd1, 5'd0);
    do_push(8'h44, 6'd2, 5'd1);
    @(posedge clk); #1;
    bus.pop = 1'b1;
    @(posedge clk); #1;
    bus.pop = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_pop = 8'h00;
    @(negedge clk);
    check("capclr_count", {26'd0, bus.count}, 32'd0);
    check("capclr_pop_data", {24'd0, bus.pop_data}, 32'd0);
    check("capclr_done", {31'd0, bus.done}, 32'd0);
    check("capclr_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);

    // clear during WR still writes but leaves count at 0
    @(posedge clk); #1;
    bus.push = 1'b1; bus.push_data = 8'h55;
    @(posedge clk); #1;
    bus.push = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check("wrclr_we", {31'd0, bus.mem_we}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("wrclr_count", {26'd0, bus.count}, 32'd0);
    check("wrclr_done", {31'd0, bus.done}, 32'd0);
    check("wrclr_empty", {31'd0, bus.empty}, 32'd1);
    repeat (3) @(negedge clk);

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/stack_pointer_ctrl.md
STACK_POINTER_CTRL -- requirements
Module: stack_pointer_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, stack entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, memory address width; DEPTH = 2**ADDR_W = 32 entries.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have ports push and pop, each input, 1, single-cycle request strobes, sampled only while busy=0.
REQ-006 The block SHALL have port push_data, input, DATA_W, the value to push, sampled with push.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress (state != IDLE).
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse on completion of a push or pop.
REQ-009 The block SHALL have port pop_data, output, DATA_W, the last popped value, held until the next pop completes.
REQ-010 The block SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W) for an external synchronous RAM with 1-cycle read latency.
REQ-011 The block SHALL have ports count (output, ADDR_W+1, number of valid entries 0..32), full (output, 1, count==32), empty (output, 1, count==0), ovf (output, 1, sticky overflow) and unf (output, 1, sticky underflow).

Function
REQ-012 States SHALL be IDLE, WR, RD, CAP.
REQ-013 IDLE with push=1, pop=0, full=0: capture push_data into the write register and go to WR.
REQ-014 WR: mem_we=1, mem_addr=count[ADDR_W-1:0], mem_wdata=the captured value; at the end of the cycle count increments by 1, state returns to IDLE and done=1 in the next cycle.
REQ-015 IDLE with pop=1, push=0, empty=0: go to RD.
REQ-016 RD: mem_addr=count-1, mem_we=0; next state CAP.
REQ-017 CAP: pop_data loads mem_rdata, count decrements by 1, state returns to IDLE and done=1 in the next cycle.
REQ-018 Latency SHALL be: push request in cycle n gives done in cycle n+2; pop request in cycle n gives done in cycle n+3.
REQ-019 In IDLE, requests SHALL be accepted in the same cycle that done is high.
REQ-020 Push while full SHALL leave the state at IDLE, leave count unchanged, keep mem_we=0 and set ovf from the next cycle.
REQ-021 Pop while empty SHALL leave the state at IDLE, leave count unchanged and set unf from the next cycle.
REQ-022 push=1 and pop=1 together in IDLE SHALL perform no operation and set no flag.
REQ-023 Requests while busy=1 SHALL be ignored and not queued.
REQ-024 mem_we SHALL be high only in WR.
REQ-025 Outside WR and RD, mem_addr SHALL equal count[ADDR_W-1:0].
REQ-026 count SHALL never wrap: it saturates at 0..32, enforced by the full and empty guards.
REQ-027 full and empty SHALL be decoded combinationally from count.

Reset
REQ-028 clr=1 SHALL, at the next edge, set state=IDLE, count=0, pop_data=0, done=0, ovf=0, unf=0 and the write register to 0.
REQ-029 clr SHALL take priority over every request and abort any in-flight operation; a WR that coincides with clr SHALL still drive mem_we for that cycle, but count SHALL end at 0.
REQ-030 After clr: busy=0, empty=1, full=0.

Structure
REQ-031 Package stack_pkg SHALL hold DEPTH, the ADDR_W/DATA_W defaults and the state encoding constants.
REQ-032 The count register SHALL be a sub-module updown_counter (inc, dec, clr; width ADDR_W+1), instantiated once.

Verification
REQ-033 Reset then push 0x05 -> mem_we=1 at addr 0 in cycle n+1, done in cycle n+2, count=1.
REQ-034 Push 0x01, 0x02, 0x03, then pop three times -> pop_data 0x03, 0x02, 0x01, each done at n+3, final count=0 and empty=1.
REQ-035 Push 32 values, then a 33rd push -> full=1, no mem_we, ovf=1, count=32.
REQ-036 Pop at reset -> unf=1, busy stays 0, no done.
REQ-037 push and pop together in IDLE -> no operation; push asserted during RD -> ignored; clr asserted during CAP -> count=0, pop_data=0, no done.
